systolic_pe_int: RTL and testbench

Parametrised integer systolic processing element, successor to the bfloat16 systolic_cell.
- Multiplies signed A×B operands and accumulates into a wide accumulator.
- Forwards A and B one cycle later to the east and south neighbours.
- Adds an explicit start/accumulate/drain state machine, a daisy-chained result drain path, and optional saturation with a sticky overflow flag.
- Tiles into an N×M array; the drain chain runs along each column.

---
 rtl/systolic_pe_int.sv | 131 +++++++++++++
 tb/tb_systolic_pe_int.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_pe_int.sv
// Integer systolic processing element: signed MAC into a wide accumulator,
// east/south operand forwarding, and a per-column daisy-chained result drain.
module systolic_pe_int #(
    parameter int DW  = 8,
    parameter int AW  = 24,
    parameter int SAT = 1,
    parameter int CW  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          drain,
    input  logic          in_valid,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic          out_valid,
    input  logic [AW-1:0] c_in,
    input  logic          c_in_valid,
    output logic [AW-1:0] c_out,
    output logic          c_out_valid,
    output logic          ovf,
    output logic [CW-1:0] mac_cnt,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t state, state_nxt;

    logic [AW-1:0]       acc, acc_nxt;
    logic [CW-1:0]       cnt_nxt;
    logic                ovf_nxt;
    logic [AW-1:0]       c_nxt;
    logic                cv_nxt;

    logic signed [2*DW-1:0] prod;
    logic [AW:0]            prod_ext;
    logic [AW:0]            sum;
    logic                   ovf_now;
    logic [AW-1:0]          acc_sum;

    assign prod     = $signed(a_in) * $signed(b_in);
    assign prod_ext = {{(AW+1-2*DW){prod[2*DW-1]}}, prod};
    assign sum      = {acc[AW-1], acc} + prod_ext;

    // One guard bit: the sum left the AW-bit range when the top two bits disagree.
    assign ovf_now = sum[AW] ^ sum[AW-1];

    always_comb begin
        acc_sum = sum[AW-1:0];
        if (ovf_now && SAT != 0)
            acc_sum = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = mac_cnt;
        ovf_nxt   = ovf;
        c_nxt     = c_out;
        cv_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (drain) begin
                    state_nxt = DRAIN;
                    c_nxt     = acc;
                    cv_nxt    = 1'b1;
                end else if (start) begin
                    state_nxt = ACCUM;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                end
            end
            ACCUM: begin
                if (drain) begin
                    state_nxt = DRAIN;
                    c_nxt     = acc;
                    cv_nxt    = 1'b1;
                end else if (start) begin
                    // Restart folds the same-edge operand pair in as the first product.
                    acc_nxt = in_valid ? prod_ext[AW-1:0] : '0;
                    cnt_nxt = in_valid ? CW'(1) : '0;
                    ovf_nxt = 1'b0;
                end else if (in_valid) begin
                    acc_nxt = acc_sum;
                    if (mac_cnt != '1)
                        cnt_nxt = mac_cnt + CW'(1);
                    if (ovf_now)
                        ovf_nxt = 1'b1;
                end
            end
            DRAIN: begin
                c_nxt  = c_in;
                cv_nxt = c_in_valid;
                if (!c_in_valid)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            mac_cnt     <= '0;
            ovf         <= 1'b0;
            c_out       <= '0;
            c_out_valid <= 1'b0;
            a_out       <= '0;
            b_out       <= '0;
            out_valid   <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            mac_cnt     <= cnt_nxt;
            ovf         <= ovf_nxt;
            c_out       <= c_nxt;
            c_out_valid <= cv_nxt;
            a_out       <= a_in;
            b_out       <= b_in;
            out_valid   <= in_valid;
        end
    end

endmodule

// File: tb/tb_systolic_pe_int.sv
// Directed bench for systolic_pe_int: a default-width PE plus two 16-bit
// accumulator PEs (saturating and wrapping) driven from the same stimulus.
module tb_systolic_pe_int;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        drain;
    logic        in_valid;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic [23:0] c_in;
    logic        c_in_valid;

    logic [7:0]  a_out0, b_out0, a_out1, b_out1, a_out2, b_out2;
    logic        ov0, ov1, ov2;
    logic [23:0] c_out0;
    logic [15:0] c_out1, c_out2;
    logic        cv0, cv1, cv2;
    logic        ovf0, ovf1, ovf2;
    logic [7:0]  cnt0, cnt1, cnt2;
    logic        busy0, busy1, busy2;

    int checks = 0;
    int passes = 0;

    systolic_pe_int #(.DW(8), .AW(24), .SAT(1), .CW(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .drain(drain),
        .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
        .a_out(a_out0), .b_out(b_out0), .out_valid(ov0),
        .c_in(c_in), .c_in_valid(c_in_valid),
        .c_out(c_out0), .c_out_valid(cv0),
        .ovf(ovf0), .mac_cnt(cnt0), .busy(busy0)
    );

    systolic_pe_int #(.DW(8), .AW(16), .SAT(1), .CW(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .drain(drain),
        .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
        .a_out(a_out1), .b_out(b_out1), .out_valid(ov1),
        .c_in(c_in[15:0]), .c_in_valid(c_in_valid),
        .c_out(c_out1), .c_out_valid(cv1),
        .ovf(ovf1), .mac_cnt(cnt1), .busy(busy1)
    );

    systolic_pe_int #(.DW(8), .AW(16), .SAT(0), .CW(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .drain(drain),
        .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
        .a_out(a_out2), .b_out(b_out2), .out_valid(ov2),
        .c_in(c_in[15:0]), .c_in_valid(c_in_valid),
        .c_out(c_out2), .c_out_valid(cv2),
        .ovf(ovf2), .mac_cnt(cnt2), .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic v);
        a_in     = a;
        b_in     = b;
        in_valid = v;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_drain();
        drain = 1'b1;
        cyc();
        drain = 1'b0;
    endtask

    task automatic end_drain();
        c_in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom); drain = 1'($urandom); in_valid = 1'($urandom);
            a_in = 8'($urandom); b_in = 8'($urandom);
            c_in = 24'($urandom); c_in_valid = 1'($urandom);
            cyc();
        end
        checks++;
        if ({a_out0, b_out0, ov0, c_out0, cv0, ovf0, cnt0, busy0} !== '0)
            $display("FAIL reset_dut0 got a=%h b=%h ov=%b c=%h cv=%b ovf=%b cnt=%0d busy=%b exp all 0",
                     a_out0, b_out0, ov0, c_out0, cv0, ovf0, cnt0, busy0);
        else passes++;
        checks++;
        if ({c_out1, cv1, ovf1, cnt1, busy1, c_out2, cv2, ovf2, cnt2, busy2} !== '0)
            $display("FAIL reset_dut12 got c1=%h c2=%h busy1=%b busy2=%b exp all 0",
                     c_out1, c_out2, busy1, busy2);
        else passes++;
        start = 0; drain = 0; in_valid = 0; a_in = 0; b_in = 0; c_in = 0; c_in_valid = 0;
        rst_n = 1'b1;
        cyc();
        checks++;
        if (busy0 !== 1'b0 || cv0 !== 1'b0)
            $display("FAIL reset_release got busy=%b cv=%b exp 0 0", busy0, cv0);
        else passes++;
    endtask

    task automatic test_accumulate();
        pulse_start();
        checks++;
        if (busy0 !== 1'b1 || cnt0 !== 8'd0)
            $display("FAIL acc_start got busy=%b cnt=%0d exp 1 0", busy0, cnt0);
        else passes++;
        drive(8'd1, 8'd1, 1'b1);
        repeat (10) cyc();
        drive(8'd0, 8'd0, 1'b0);
        do_drain();
        checks++;
        if (c_out0 !== 24'd10 || cv0 !== 1'b1 || cnt0 !== 8'd10)
            $display("FAIL acc_drain got c=%0d cv=%b cnt=%0d exp 10 1 10", c_out0, cv0, cnt0);
        else passes++;
        end_drain();
        checks++;
        if (busy0 !== 1'b0 || cv0 !== 1'b0)
            $display("FAIL acc_idle got busy=%b cv=%b exp 0 0", busy0, cv0);
        else passes++;
    endtask

    task automatic test_signed();
        logic [7:0] av [3];
        logic [7:0] bv [3];
        logic [7:0] pa, pb;
        int bad;
        av[0] = 8'h80; bv[0] = 8'h80;   // -128 * -128
        av[1] = 8'hFD; bv[1] = 8'd5;    // -3 * 5
        av[2] = 8'd7;  bv[2] = 8'hFF;   // 7 * -1
        bad = 0;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            drive(av[i], bv[i], 1'b1);
            pa = av[i]; pb = bv[i];
            cyc();
            if (a_out0 !== pa || b_out0 !== pb || ov0 !== 1'b1) bad++;
        end
        drive(8'h5A, 8'hC3, 1'b0);
        cyc();
        if (a_out0 !== 8'h5A || b_out0 !== 8'hC3 || ov0 !== 1'b0) bad++;
        checks++;
        if (bad != 0)
            $display("FAIL passthrough got %0d bad cycles exp 0", bad);
        else passes++;
        drive(8'd0, 8'd0, 1'b0);
        do_drain();
        checks++;
        if (c_out0 !== 24'd16362 || cv0 !== 1'b1)
            $display("FAIL signed_sum got c=%0d cv=%b exp 16362 1", c_out0, cv0);
        else passes++;
        end_drain();
    endtask

    task automatic test_saturation();
        pulse_start();
        drive(8'd127, 8'd127, 1'b1);
        repeat (3) cyc();
        drive(8'd0, 8'd0, 1'b0);
        do_drain();
        checks++;
        if (c_out1 !== 16'h7FFF || ovf1 !== 1'b1)
            $display("FAIL sat_clamp got c=%h ovf=%b exp 7fff 1", c_out1, ovf1);
        else passes++;
        checks++;
        if (c_out2 !== 16'hBD03 || ovf2 !== 1'b1)
            $display("FAIL sat_wrap got c=%h ovf=%b exp bd03 1", c_out2, ovf2);
        else passes++;
        checks++;
        if (c_out0 !== 24'd48387 || ovf0 !== 1'b0)
            $display("FAIL sat_wide got c=%0d ovf=%b exp 48387 0", c_out0, ovf0);
        else passes++;
        end_drain();
        checks++;
        if (ovf1 !== 1'b1 || ovf2 !== 1'b1)
            $display("FAIL ovf_sticky got %b %b exp 1 1", ovf1, ovf2);
        else passes++;
        pulse_start();
        checks++;
        if (ovf1 !== 1'b0 || ovf2 !== 1'b0)
            $display("FAIL ovf_clear got %b %b exp 0 0", ovf1, ovf2);
        else passes++;
        do_drain();
        end_drain();
    endtask

    task automatic test_drain_chain();
        pulse_start();
        drive(8'd6, 8'd7, 1'b1);
        cyc();
        drive(8'd0, 8'd0, 1'b0);
        do_drain();
        checks++;
        if (c_out0 !== 24'd42 || cv0 !== 1'b1)
            $display("FAIL chain_0 got c=%0d cv=%b exp 42 1", c_out0, cv0);
        else passes++;
        c_in = 24'd7; c_in_valid = 1'b1;
        cyc();
        checks++;
        if (c_out0 !== 24'd7 || cv0 !== 1'b1 || busy0 !== 1'b1)
            $display("FAIL chain_1 got c=%0d cv=%b busy=%b exp 7 1 1", c_out0, cv0, busy0);
        else passes++;
        c_in = 24'd8;
        cyc();
        checks++;
        if (c_out0 !== 24'd8 || cv0 !== 1'b1)
            $display("FAIL chain_2 got c=%0d cv=%b exp 8 1", c_out0, cv0);
        else passes++;
        end_drain();
        checks++;
        if (cv0 !== 1'b0 || busy0 !== 1'b0)
            $display("FAIL chain_end got cv=%b busy=%b exp 0 0", cv0, busy0);
        else passes++;
        c_in = 24'd0;
    endtask

    task automatic test_corners();
        pulse_start();
        drive(8'd2, 8'd3, 1'b1); cyc();
        drive(8'd4, 8'd5, 1'b1); cyc();
        drive(8'd0, 8'd0, 1'b0);
        start = 1'b1; drain = 1'b1;
        cyc();
        start = 1'b0; drain = 1'b0;
        checks++;
        if (c_out0 !== 24'd26 || cv0 !== 1'b1 || busy0 !== 1'b1 || cnt0 !== 8'd2)
            $display("FAIL start_drain got c=%0d cv=%b busy=%b cnt=%0d exp 26 1 1 2",
                     c_out0, cv0, busy0, cnt0);
        else passes++;
        end_drain();

        pulse_start();
        drive(8'd3, 8'd3, 1'b1); cyc();
        drive(8'd100, 8'd100, 1'b1);
        do_drain();
        drive(8'd0, 8'd0, 1'b0);
        checks++;
        if (c_out0 !== 24'd9 || cnt0 !== 8'd1)
            $display("FAIL drain_edge got c=%0d cnt=%0d exp 9 1", c_out0, cnt0);
        else passes++;
        end_drain();
        do_drain();
        checks++;
        if (c_out0 !== 24'd9 || cv0 !== 1'b1)
            $display("FAIL acc_held got c=%0d cv=%b exp 9 1", c_out0, cv0);
        else passes++;
        end_drain();

        pulse_start();
        drive(8'd2, 8'd2, 1'b1); cyc();
        drive(8'd3, 8'd4, 1'b1);
        pulse_start();
        drive(8'd0, 8'd0, 1'b0);
        checks++;
        if (cnt0 !== 8'd1 || busy0 !== 1'b1)
            $display("FAIL restart_cnt got cnt=%0d busy=%b exp 1 1", cnt0, busy0);
        else passes++;
        do_drain();
        checks++;
        if (c_out0 !== 24'd12)
            $display("FAIL restart_acc got c=%0d exp 12", c_out0);
        else passes++;
        end_drain();

        pulse_start();
        drive(8'd1, 8'd1, 1'b1);
        repeat (260) cyc();
        drive(8'd0, 8'd0, 1'b0);
        checks++;
        if (cnt0 !== 8'd255)
            $display("FAIL cnt_sat got %0d exp 255", cnt0);
        else passes++;

        pulse_start();
        drive(8'd5, 8'd5, 1'b1);
        repeat (5) cyc();
        drive(8'd0, 8'd0, 1'b0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        checks++;
        if (cnt0 !== 8'd0 || busy0 !== 1'b0 || ovf0 !== 1'b0)
            $display("FAIL mid_reset got cnt=%0d busy=%b ovf=%b exp 0 0 0", cnt0, busy0, ovf0);
        else passes++;
        do_drain();
        checks++;
        if (c_out0 !== 24'd0 || cv0 !== 1'b1)
            $display("FAIL mid_reset_acc got c=%0d cv=%b exp 0 1", c_out0, cv0);
        else passes++;
        end_drain();
    endtask

    initial begin
        rst_n = 1'b0; start = 0; drain = 0; in_valid = 0;
        a_in = 0; b_in = 0; c_in = 0; c_in_valid = 0;
        test_reset();
        test_accumulate();
        test_signed();
        test_saturation();
        test_drain_chain();
        test_corners();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
